// File: rtl/pll_clk_pkg.sv
// Shared constants and helpers for the digital PLL stand-in.
// Holds the legal ranges of the four block parameters and the width and
// phase-preset helpers used by pll_lock_timer and pll_clk_synth.
package pll_clk_pkg;

  localparam int unsigned C0DivMin  = 2;
  localparam int unsigned C0DivMax  = 256;
  localparam int unsigned C0HighMin = 1;
  localparam int unsigned LockMin   = 1;
  localparam int unsigned LockMax   = 65535;

  // Bits needed to hold every value 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Bits needed for a phase counter that runs 0..div-1.
  function automatic int unsigned ph_width(input int unsigned div);
    return (div < 3) ? 1 : $clog2(div);
  endfunction

  // Phase counter preset.
  // Choosing (div - phase) % div delays the first high pulse by phase cycles.
  function automatic int unsigned ph_init(input int unsigned div, input int unsigned phase);
    return (div - phase) % div;
  endfunction

endpackage

// File: rtl/pll_lock_timer.sv
// Lock timer for the PLL stand-in.
// Counts clk rising edges after areset_n is released and raises locked once
// LOCK_CYCLES edges have been seen. The counter saturates, so locked stays high
// until the next reset.
// Ports:
//   clk         in   reference clock, rising edge
//   areset_n    in   asynchronous active-low reset
//   locked      out  registered lock flag
//   locked_next out  value locked takes at the coming edge; the divider uses it
//                    to start on the same edge that locked rises
module pll_lock_timer
  import pll_clk_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES = 64
) (
  input  logic clk,
  input  logic areset_n,
  output logic locked,
  output logic locked_next
);

  localparam int unsigned CntW = cnt_width(LOCK_CYCLES);

  if (LOCK_CYCLES < LockMin || LOCK_CYCLES > LockMax) begin : g_bad_lock
    $error("pll_lock_timer: LOCK_CYCLES out of range 1..65535");
  end

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            locked_q, locked_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != CntW'(LOCK_CYCLES)) begin
      cnt_d = cnt_q + 1'b1;
    end
    // Set on the edge where the count moves from LOCK_CYCLES-1 to LOCK_CYCLES.
    locked_d = locked_q | (cnt_q == CntW'(LOCK_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  assign locked      = locked_q;
  assign locked_next = locked_d;

endmodule

// File: rtl/pll_clk_synth.sv
// Digital stand-in for the system PLL primitive.
// c0 is clk divided by C0_DIV. It is high for C0_HIGH cycles of each period
// and is shifted by C0_PHASE cycles. c0 is held low until the lock timer expires.
// Ports:
//   clk       in   reference clock, rising edge
//   areset_n  in   asynchronous active-low reset
//   clkena    in   c0 enable; 0 holds c0 low while the phase keeps running
//   c0        out  divided clock, registered
//   locked    out  high once LOCK_CYCLES edges have elapsed since reset
module pll_clk_synth
  import pll_clk_pkg::*;
#(
  parameter int unsigned C0_DIV      = 4,
  parameter int unsigned C0_HIGH     = 2,
  parameter int unsigned C0_PHASE    = 0,
  parameter int unsigned LOCK_CYCLES = 64
) (
  input  logic clk,
  input  logic areset_n,
  input  logic clkena,
  output logic c0,
  output logic locked
);

  localparam int unsigned   PhW    = ph_width(C0_DIV);
  localparam logic [PhW-1:0] PhInit = PhW'(ph_init(C0_DIV, C0_PHASE));
  localparam logic [PhW-1:0] PhLast = PhW'(C0_DIV - 1);
  localparam logic [PhW-1:0] PhHigh = PhW'(C0_HIGH);

  if (C0_DIV < C0DivMin || C0_DIV > C0DivMax) begin : g_bad_div
    $error("pll_clk_synth: C0_DIV out of range 2..256");
  end
  if (C0_HIGH < C0HighMin || C0_HIGH >= C0_DIV) begin : g_bad_high
    $error("pll_clk_synth: C0_HIGH out of range 1..C0_DIV-1");
  end
  if (C0_PHASE >= C0_DIV) begin : g_bad_phase
    $error("pll_clk_synth: C0_PHASE out of range 0..C0_DIV-1");
  end

  logic           locked_q;
  logic           locked_next;
  logic [PhW-1:0] ph_q, ph_d;
  logic           c0_q, c0_d;

  pll_lock_timer #(
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_lock_timer (
    .clk         (clk),
    .areset_n    (areset_n),
    .locked      (locked_q),
    .locked_next (locked_next)
  );

  always_comb begin
    if (locked_q) begin
      ph_d = (ph_q == PhLast) ? '0 : ph_q + 1'b1;
    end else begin
      // Held at the preset while unlocked, so the locking edge lands on PhInit.
      ph_d = PhInit;
    end
    // Decode from the next phase so that c0 stays aligned with ph as registered.
    c0_d = clkena & locked_next & (ph_d < PhHigh);
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      ph_q <= '0;
      c0_q <= 1'b0;
    end else begin
      ph_q <= ph_d;
      c0_q <= c0_d;
    end
  end

  assign c0     = c0_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_pll_clk_synth.sv
// Bench for pll_clk_synth. It runs three configurations side by side:
//   dut0: default parameters
//   dut1: DIV 5, HIGH 3, PHASE 2, LOCK 4
//   dut2: DIV 2, HIGH 1, PHASE 0, LOCK 1
// Each configuration is checked against an arithmetic model that works from
// the number of edges seen since reset release.
module tb_pll_clk_synth;

  logic       clk = 1'b0;
  logic [2:0] rst_n;
  logic [2:0] en;
  logic [2:0] c0_w;
  logic [2:0] lk_w;

  int total = 0;
  int bad   = 0;
  int n[3];
  int run[3];

  typedef struct {
    logic en;
    logic c0;
    logic lk;
  } vec_t;

  vec_t tbl[14];

  always #5 clk = ~clk;

  pll_clk_synth u_dut0 (
    .clk      (clk),
    .areset_n (rst_n[0]),
    .clkena   (en[0]),
    .c0       (c0_w[0]),
    .locked   (lk_w[0])
  );

  pll_clk_synth #(
    .C0_DIV      (5),
    .C0_HIGH     (3),
    .C0_PHASE    (2),
    .LOCK_CYCLES (4)
  ) u_dut1 (
    .clk      (clk),
    .areset_n (rst_n[1]),
    .clkena   (en[1]),
    .c0       (c0_w[1]),
    .locked   (lk_w[1])
  );

  pll_clk_synth #(
    .C0_DIV      (2),
    .C0_HIGH     (1),
    .C0_PHASE    (0),
    .LOCK_CYCLES (1)
  ) u_dut2 (
    .clk      (clk),
    .areset_n (rst_n[2]),
    .clkena   (en[2]),
    .c0       (c0_w[2]),
    .locked   (lk_w[2])
  );

  function automatic int p_div(input int k);
    case (k)
      0: return 4;
      1: return 5;
      default: return 2;
    endcase
  endfunction

  function automatic int p_high(input int k);
    case (k)
      0: return 2;
      1: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int p_phase(input int k);
    case (k)
      1: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int p_lock(input int k);
    case (k)
      0: return 64;
      1: return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int exp_locked(input int k);
    return (n[k] >= p_lock(k)) ? 1 : 0;
  endfunction

  // c0 is high when the edges elapsed since lock, less the phase offset and
  // taken modulo the period, fall inside the high window.
  function automatic int exp_c0(input int k, input logic en_at_edge);
    int e;
    if (!en_at_edge || exp_locked(k) == 0) return 0;
    e = n[k] - p_lock(k);
    return (((e + p_div(k) - p_phase(k)) % p_div(k)) < p_high(k)) ? 1 : 0;
  endfunction

  task automatic chk(input int k, input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL dut%0d %s: got %0d expected %0d at %0t", k, name, act, exp, $time);
    end
  endtask

  // One clk edge. Afterwards every configuration is compared with the model.
  task automatic tick();
    logic [2:0] en_s;
    logic [2:0] rst_s;
    en_s  = en;
    rst_s = rst_n;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (rst_s[k]) n[k]++;
      else n[k] = 0;
      chk(k, "model_locked", int'(lk_w[k]), exp_locked(k));
      chk(k, "model_c0", int'(c0_w[k]), exp_c0(k, en_s[k]));
      if (c0_w[k]) begin
        run[k]++;
        chk(k, "pulse_within_high", (run[k] <= p_high(k)) ? 1 : 0, 1);
        chk(k, "c0_implies_locked", int'(lk_w[k]), 1);
      end else begin
        run[k] = 0;
      end
    end
  endtask

  initial begin
    bit found;

    tbl[0]  = '{en: 1'b1, c0: 1'b0, lk: 1'b0};
    tbl[1]  = '{en: 1'b1, c0: 1'b0, lk: 1'b0};
    tbl[2]  = '{en: 1'b1, c0: 1'b0, lk: 1'b0};
    tbl[3]  = '{en: 1'b1, c0: 1'b0, lk: 1'b1};
    tbl[4]  = '{en: 1'b1, c0: 1'b0, lk: 1'b1};
    tbl[5]  = '{en: 1'b1, c0: 1'b1, lk: 1'b1};
    tbl[6]  = '{en: 1'b1, c0: 1'b1, lk: 1'b1};
    tbl[7]  = '{en: 1'b1, c0: 1'b1, lk: 1'b1};
    tbl[8]  = '{en: 1'b1, c0: 1'b0, lk: 1'b1};
    tbl[9]  = '{en: 1'b1, c0: 1'b0, lk: 1'b1};
    tbl[10] = '{en: 1'b1, c0: 1'b1, lk: 1'b1};
    tbl[11] = '{en: 1'b0, c0: 1'b0, lk: 1'b1};
    tbl[12] = '{en: 1'b1, c0: 1'b1, lk: 1'b1};
    tbl[13] = '{en: 1'b1, c0: 1'b0, lk: 1'b1};

    for (int k = 0; k < 3; k++) begin
      n[k]   = 0;
      run[k] = 0;
    end
    rst_n = 3'b000;
    en    = 3'b111;

    // Reset state.
    repeat (2) tick();
    for (int k = 0; k < 3; k++) begin
      chk(k, "reset_c0", int'(c0_w[k]), 0);
      chk(k, "reset_locked", int'(lk_w[k]), 0);
    end

    // Release all resets together and walk dut1 through its vector table.
    rst_n = 3'b111;
    for (int i = 0; i < 14; i++) begin
      en[1] = tbl[i].en;
      tick();
      chk(1, "tbl_c0", int'(c0_w[1]), int'(tbl[i].c0));
      chk(1, "tbl_locked", int'(lk_w[1]), int'(tbl[i].lk));
      // dut2 locks on edge 1 and toggles at clk/2 from there.
      chk(2, "fast_locked", int'(lk_w[2]), 1);
      chk(2, "fast_c0", int'(c0_w[2]), (i % 2 == 0) ? 1 : 0);
    end
    en[1] = 1'b1;

    // dut0 must not be locked on edge 63, and must be locked with c0 high on edge 64.
    repeat (49) tick();
    chk(0, "locked_edge63", int'(lk_w[0]), 0);
    chk(0, "c0_edge63", int'(c0_w[0]), 0);
    tick();
    chk(0, "locked_edge64", int'(lk_w[0]), 1);
    chk(0, "c0_edge64", int'(c0_w[0]), 1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk(0, "period4_pattern", int'(c0_w[0]), ((i % 4) < 2) ? 1 : 0);
    end

    // Disable dut0 for 7 cycles; the model then covers the resumed phase.
    en[0] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk(0, "disabled_c0", int'(c0_w[0]), 0);
    end
    en[0] = 1'b1;
    repeat (8) tick();

    // Assert the async reset in the middle of a high phase of dut0.
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (c0_w[0]) found = 1'b1;
    end
    chk(0, "wait_c0_high", int'(found), 1);
    #2;
    rst_n[0] = 1'b0;
    n[0]     = 0;
    run[0]   = 0;
    #1;
    chk(0, "async_c0_drop", int'(c0_w[0]), 0);
    chk(0, "async_locked_drop", int'(lk_w[0]), 0);
    repeat (2) tick();
    rst_n[0] = 1'b1;
    repeat (63) tick();
    chk(0, "relock_edge63", int'(lk_w[0]), 0);
    tick();
    chk(0, "relock_edge64", int'(lk_w[0]), 1);

    // Random enables on every configuration.
    for (int i = 0; i < 10000; i++) begin
      en = 3'($urandom_range(0, 7));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
